cr_iu_wb_arb: RTL and testbench
===============================

Name: cr_iu_wb_arb

Overview:
Write-back arbiter that sits directly upstream of the bank of gated-clock 32-bit registers.
- Sources: ALU (single-cycle, must never stall), LSU load return and divider result (both valid/ready).
- Selects one winner per cycle and stages it for one cycle.
- Drives a one-hot per-register write enable, shared write data, and the module-level clock-enable for the register bank.

Parameters:
- REG_NUM, 16, number of target registers in the bank.
- IDXW, 4, register index width; must satisfy 2^IDXW >= REG_NUM.
- STARVE_LIMIT, 4, consecutive divider denials before the divider is forced to win over the LSU.
- ZERO_REG_WIRED, 1, when 1 a write to index 0 completes its handshake but produces no register write.

Ports:
- forever_cpuclk  in  1  free-running CPU clock.
- cpurst  in  1  reset.
- alu_wb_vld  in  1  ALU result valid; has no ready and is always accepted.
- alu_wb_idx  in  IDXW  ALU destination index.
- alu_wb_data  in  32  ALU result.
- lsu_wb_vld  in  1  load-return valid.
- lsu_wb_idx  in  IDXW  load destination index.
- lsu_wb_data  in  32  load data.
- lsu_wb_rdy  out  1  load-return accepted this cycle.
- div_wb_vld  in  1  divider result valid.
- div_wb_idx  in  IDXW  divider destination index.
- div_wb_data  in  32  divider result.
- div_wb_rdy  out  1  divider result accepted this cycle.
- x_write_en  out  REG_NUM  one-hot write enable, one bit per register.
- write_data  out  32  shared write data for the register bank.
- x_randclk_reg_mod_en_w32  out  1  module clock enable for the register bank.
- wb_idx_err  out  1  sticky flag: a write with index >= REG_NUM was dropped.

Behaviour:
Clock and reset (already decided):
- One clock, forever_cpuclk.
- Reset cpurst is synchronous and active-high.

Reset values:
- x_write_en=0, write_data=0, x_randclk_reg_mod_en_w32=0, wb_idx_err=0, starve_cnt=0.

Grant, combinational, evaluated every cycle:
- starve_hit = (starve_cnt == STARVE_LIMIT) & div_wb_vld.
- lsu_wb_rdy = !alu_wb_vld & !starve_hit.
- div_wb_rdy = !alu_wb_vld & (starve_hit | !lsu_wb_vld).
- The ready outputs do not depend on the requester's own valid.
- A handshake completes when vld & rdy.
- Winner priority: ALU > starved DIV > LSU > DIV. At most one source wins per cycle.

Starve counter:
- Increments, saturating at STARVE_LIMIT, when div_wb_vld & !div_wb_rdy.
- Clears to 0 on a divider handshake, or when div_wb_vld=0.

Staging, latency 1 cycle:
- Winner with a legal index (idx < REG_NUM, and not idx 0 when ZERO_REG_WIRED=1):
  - next cycle x_write_en = one-hot(idx);
  - next cycle write_data = winner data.
- Otherwise next cycle x_write_en = 0 and write_data holds its value, so there is no data toggling while idle.
- x_randclk_reg_mod_en_w32 is registered and equals |next x_write_en, so it is coincident with x_write_en.

Illegal and dropped writes:
- Winner with idx >= REG_NUM: handshake still completes, no write, wb_idx_err is set.
- wb_idx_err clears only on reset.
- Index 0 with ZERO_REG_WIRED=1: handshake completes, no write, no error.

Boundary conditions:
- ALU and LSU valid together: LSU is stalled (rdy=0) and must hold its request; the counter is unaffected.
- All three valid: only the ALU is written.
- Divider valid continuously under LSU traffic: the divider wins on the cycle after STARVE_LIMIT denials; the counter then returns to 0.
- Reset asserted mid-operation: the staged write is discarded; outputs take reset values the following cycle.
- Ready is 0 during reset.

Decomposition:
- Shared package cr_iu_wb_pkg holds:
  - source-select encoding SRC_NONE/ALU/LSU/DIV;
  - the one-hot decode function.
- One natural sub-module, cr_iu_wb_starve_cnt: the saturating denial counter, outputting starve_cnt == STARVE_LIMIT.

Test Plan:
- ALU only: alu_wb_vld=1, idx=5, data=0xDEADBEEF.
  -> Next cycle x_write_en=0x0020, write_data=0xDEADBEEF, x_randclk_reg_mod_en_w32=1.
  -> The cycle after that, x_write_en=0.
- ALU and LSU same cycle: alu idx=3, lsu idx=7 data=0x1234.
  -> lsu_wb_rdy=0, x_write_en=0x0008.
  -> With the LSU held, the following cycle x_write_en=0x0080, write_data=0x1234.
- Starvation: LSU and DIV valid continuously, STARVE_LIMIT=4.
  -> div_wb_rdy=0 for 4 cycles, then div_wb_rdy=1 and lsu_wb_rdy=0 on cycle 5.
  -> Counter returns to 0.
- Index 0: LSU writes idx=0 with ZERO_REG_WIRED=1.
  -> lsu_wb_rdy=1, x_write_en stays 0, wb_idx_err=0.
- Illegal index: REG_NUM=12, div idx=14.
  -> Handshake completes, no write, wb_idx_err=1 and sticky until cpurst.
- Reset mid-stream: assert cpurst in the cycle after an ALU write is accepted.
  -> Next cycle x_write_en=0, write_data=0, starve_cnt=0, wb_idx_err=0.

Source files
------------

// File: rtl/cr_iu_wb_pkg.sv
// Shared definitions for the integer-unit write-back arbiter.
// - wb_src_e  : which source won the write-back port this cycle.
// - wb_onehot : index to one-hot decode used for per-register write enables.
package cr_iu_wb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_DIV  = 2'd3
    } wb_src_e;

    // Widest register bank the decoder supports; callers size-cast the result.
    localparam int unsigned WB_MAX_REGS = 64;
    localparam int unsigned WB_DEC_IDXW = 6;

    function automatic logic [WB_MAX_REGS-1:0] wb_onehot(input logic [WB_DEC_IDXW-1:0] idx);
        logic [WB_MAX_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cr_iu_wb_starve_cnt.sv
// Saturating count of consecutive cycles the divider result was denied.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   div_vld  - divider result valid
//   div_rdy  - divider result accepted this cycle
//   at_limit - count has reached STARVE_LIMIT
module cr_iu_wb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic div_vld,
    input  logic div_rdy,
    output logic at_limit
);

    localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_VAL = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // A granted or withdrawn divider request ends the denial streak.
        if (!div_vld || div_rdy) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT_VAL) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_VAL);

endmodule

// File: rtl/cr_iu_wb_arb.sv
// Write-back arbiter in front of the gated-clock 32-bit register bank.
// Picks one of ALU / LSU / DIV per cycle and stages it for one cycle.
// Ports:
//   forever_cpuclk, cpurst          - clock, synchronous active-high reset
//   alu_wb_vld/idx/data             - ALU result, always accepted
//   lsu_wb_vld/idx/data, lsu_wb_rdy - load return, valid/ready
//   div_wb_vld/idx/data, div_wb_rdy - divider result, valid/ready
//   x_write_en                      - registered one-hot per-register write enable
//   write_data                      - registered shared write data
//   x_randclk_reg_mod_en_w32        - registered bank clock enable (= |x_write_en)
//   wb_idx_err                      - sticky: an out-of-range write was dropped
// REG_NUM must not exceed 2**IDXW nor WB_MAX_REGS.
module cr_iu_wb_arb
    import cr_iu_wb_pkg::*;
#(
    parameter int unsigned REG_NUM        = 16,
    parameter int unsigned IDXW           = 4,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned ZERO_REG_WIRED = 1
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               alu_wb_vld,
    input  logic [IDXW-1:0]    alu_wb_idx,
    input  logic [31:0]        alu_wb_data,
    input  logic               lsu_wb_vld,
    input  logic [IDXW-1:0]    lsu_wb_idx,
    input  logic [31:0]        lsu_wb_data,
    output logic               lsu_wb_rdy,
    input  logic               div_wb_vld,
    input  logic [IDXW-1:0]    div_wb_idx,
    input  logic [31:0]        div_wb_data,
    output logic               div_wb_rdy,
    output logic [REG_NUM-1:0] x_write_en,
    output logic [31:0]        write_data,
    output logic               x_randclk_reg_mod_en_w32,
    output logic               wb_idx_err
);

    logic               starve_at_limit;
    logic               starve_hit;
    wb_src_e            win_src;
    logic [IDXW-1:0]    win_idx;
    logic [31:0]        win_data;
    logic               idx_in_range;
    logic               zero_drop;
    logic               wr_fire;
    logic               idx_err_set;
    logic [REG_NUM-1:0] write_en_d;

    cr_iu_wb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .div_vld  (div_wb_vld),
        .div_rdy  (div_wb_rdy),
        .at_limit (starve_at_limit)
    );

    assign starve_hit = starve_at_limit & div_wb_vld;

    // Readies never look at the requester's own valid; both drop during reset.
    assign lsu_wb_rdy = !cpurst & !alu_wb_vld & !starve_hit;
    assign div_wb_rdy = !cpurst & !alu_wb_vld & (starve_hit | !lsu_wb_vld);

    // The readies already encode ALU > starved DIV > LSU > DIV, so a completed
    // handshake identifies the winner directly.
    always_comb begin
        win_src = SRC_NONE;
        if (cpurst) begin
            win_src = SRC_NONE;
        end else if (alu_wb_vld) begin
            win_src = SRC_ALU;
        end else if (lsu_wb_vld && lsu_wb_rdy) begin
            win_src = SRC_LSU;
        end else if (div_wb_vld && div_wb_rdy) begin
            win_src = SRC_DIV;
        end
    end

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        case (win_src)
            SRC_ALU: begin
                win_idx  = alu_wb_idx;
                win_data = alu_wb_data;
            end
            SRC_LSU: begin
                win_idx  = lsu_wb_idx;
                win_data = lsu_wb_data;
            end
            SRC_DIV: begin
                win_idx  = div_wb_idx;
                win_data = div_wb_data;
            end
            default: begin
                win_idx  = '0;
                win_data = '0;
            end
        endcase
    end

    assign idx_in_range = (32'(win_idx) < REG_NUM);
    assign zero_drop    = (ZERO_REG_WIRED != 0) && (win_idx == '0);
    assign wr_fire      = (win_src != SRC_NONE) && idx_in_range && !zero_drop;
    assign idx_err_set  = (win_src != SRC_NONE) && !idx_in_range;

    assign write_en_d = wr_fire ? REG_NUM'(wb_onehot(WB_DEC_IDXW'(win_idx))) : '0;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            x_write_en               <= '0;
            write_data               <= '0;
            x_randclk_reg_mod_en_w32 <= 1'b0;
            wb_idx_err               <= 1'b0;
        end else begin
            x_write_en               <= write_en_d;
            x_randclk_reg_mod_en_w32 <= |write_en_d;
            // Hold data while idle so the bank's data inputs stay quiet.
            if (wr_fire) begin
                write_data <= win_data;
            end
            if (idx_err_set) begin
                wb_idx_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cr_iu_wb_arb.sv
// Directed bench for cr_iu_wb_arb: a vector table of single-cycle cases plus
// hand-written sequences for reset mid-stream, illegal index and starvation.
module tb_cr_iu_wb_arb;

    localparam int unsigned REG_NUM = 12;
    localparam int unsigned IDXW    = 4;

    logic               clk;
    logic               rst;
    logic               alu_vld;
    logic [IDXW-1:0]    alu_idx;
    logic [31:0]        alu_data;
    logic               lsu_vld;
    logic [IDXW-1:0]    lsu_idx;
    logic [31:0]        lsu_data;
    logic               lsu_rdy;
    logic               div_vld;
    logic [IDXW-1:0]    div_idx;
    logic [31:0]        div_data;
    logic               div_rdy;
    logic [REG_NUM-1:0] we;
    logic [31:0]        wdata;
    logic               mod_en;
    logic               idx_err;

    cr_iu_wb_arb #(
        .REG_NUM        (REG_NUM),
        .IDXW           (IDXW),
        .STARVE_LIMIT   (4),
        .ZERO_REG_WIRED (1)
    ) dut (
        .forever_cpuclk           (clk),
        .cpurst                   (rst),
        .alu_wb_vld               (alu_vld),
        .alu_wb_idx               (alu_idx),
        .alu_wb_data              (alu_data),
        .lsu_wb_vld               (lsu_vld),
        .lsu_wb_idx               (lsu_idx),
        .lsu_wb_data              (lsu_data),
        .lsu_wb_rdy               (lsu_rdy),
        .div_wb_vld               (div_vld),
        .div_wb_idx               (div_idx),
        .div_wb_data              (div_data),
        .div_wb_rdy               (div_rdy),
        .x_write_en               (we),
        .write_data               (wdata),
        .x_randclk_reg_mod_en_w32 (mod_en),
        .wb_idx_err               (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic               alu_vld;
        logic [IDXW-1:0]    alu_idx;
        logic [31:0]        alu_data;
        logic               lsu_vld;
        logic [IDXW-1:0]    lsu_idx;
        logic [31:0]        lsu_data;
        logic               div_vld;
        logic [IDXW-1:0]    div_idx;
        logic [31:0]        div_data;
        logic               exp_lsu_rdy;
        logic               exp_div_rdy;
        logic [REG_NUM-1:0] exp_we;
        logic [31:0]        exp_data;
        logic               exp_err;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(
        input logic av, input logic [IDXW-1:0] ai, input logic [31:0] ad,
        input logic lv, input logic [IDXW-1:0] li, input logic [31:0] ld,
        input logic dv, input logic [IDXW-1:0] di, input logic [31:0] dd,
        input logic elr, input logic edr, input logic [REG_NUM-1:0] ewe,
        input logic [31:0] edata, input logic eerr);
        vec_t v;
        v.alu_vld = av;  v.alu_idx = ai;  v.alu_data = ad;
        v.lsu_vld = lv;  v.lsu_idx = li;  v.lsu_data = ld;
        v.div_vld = dv;  v.div_idx = di;  v.div_data = dd;
        v.exp_lsu_rdy = elr;
        v.exp_div_rdy = edr;
        v.exp_we      = ewe;
        v.exp_data    = edata;
        v.exp_err     = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_vld = v.alu_vld;  alu_idx = v.alu_idx;  alu_data = v.alu_data;
        lsu_vld = v.lsu_vld;  lsu_idx = v.lsu_idx;  lsu_data = v.lsu_data;
        div_vld = v.div_vld;  div_idx = v.div_idx;  div_data = v.div_data;
    endtask

    task automatic idle_inputs();
        alu_vld = 1'b0; alu_idx = '0; alu_data = '0;
        lsu_vld = 1'b0; lsu_idx = '0; lsu_data = '0;
        div_vld = 1'b0; div_idx = '0; div_data = '0;
    endtask

    // Readies are checked mid-cycle; staged outputs #1 after the next edge.
    task automatic check_rdy(input string tag, input logic elr, input logic edr);
        @(negedge clk);
        check({tag, ".lsu_rdy"}, 32'(lsu_rdy), 32'(elr));
        check({tag, ".div_rdy"}, 32'(div_rdy), 32'(edr));
    endtask

    task automatic check_out(input string tag, input logic [REG_NUM-1:0] ewe,
                             input logic [31:0] edata, input logic eerr);
        @(posedge clk);
        #1;
        check({tag, ".we"},     32'(we), 32'(ewe));
        check({tag, ".data"},   wdata, edata);
        check({tag, ".mod_en"}, 32'(mod_en), 32'(|ewe));
        check({tag, ".err"},    32'(idx_err), 32'(eerr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             alu               lsu                      div                    rdy l,d  we            data          err
        vecs[0]  = mk(0, 0, 0,           0, 0,  0,              0, 0, 0,              1, 1, 12'h000, 32'h0,        0);
        vecs[1]  = mk(1, 5, 32'hDEADBEEF,0, 0,  0,              0, 0, 0,              0, 0, 12'h020, 32'hDEADBEEF, 0);
        vecs[2]  = mk(0, 0, 0,           0, 0,  0,              0, 0, 0,              1, 1, 12'h000, 32'hDEADBEEF, 0);
        vecs[3]  = mk(1, 3, 32'h1111,    1, 7,  32'h1234,       0, 0, 0,              0, 0, 12'h008, 32'h1111,     0);
        vecs[4]  = mk(0, 0, 0,           1, 7,  32'h1234,       0, 0, 0,              1, 0, 12'h080, 32'h1234,     0);
        vecs[5]  = mk(0, 0, 0,           1, 0,  32'h5555,       0, 0, 0,              1, 0, 12'h000, 32'h1234,     0);
        vecs[6]  = mk(0, 0, 0,           0, 0,  0,              1, 9, 32'hA5A5,       1, 1, 12'h200, 32'hA5A5,     0);
        vecs[7]  = mk(0, 0, 0,           1, 11, 32'hCAFE0011,   0, 0, 0,              1, 0, 12'h800, 32'hCAFE0011, 0);
        vecs[8]  = mk(0, 0, 0,           1, 12, 32'h0BAD,       0, 0, 0,              1, 0, 12'h000, 32'hCAFE0011, 1);
        vecs[9]  = mk(1, 2, 32'h22,      0, 0,  0,              0, 0, 0,              0, 0, 12'h004, 32'h22,       1);
        vecs[10] = mk(1, 1, 32'h10,      1, 4,  32'h40,         1, 6, 32'h60,         0, 0, 12'h002, 32'h10,       1);
        vecs[11] = mk(0, 0, 0,           0, 0,  0,              0, 0, 0,              1, 1, 12'h000, 32'h10,       1);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.we",      32'(we), 32'h0);
        check("reset.data",    wdata, 32'h0);
        check("reset.mod_en",  32'(mod_en), 32'h0);
        check("reset.err",     32'(idx_err), 32'h0);
        check("reset.lsu_rdy", 32'(lsu_rdy), 32'h0);
        check("reset.div_rdy", 32'(div_rdy), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i]);
            check_rdy(tag, vecs[i].exp_lsu_rdy, vecs[i].exp_div_rdy);
            check_out(tag, vecs[i].exp_we, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Reset lands in the cycle the accepted ALU write is visible.
        idle_inputs();
        alu_vld = 1'b1; alu_idx = 4'd5; alu_data = 32'h77;
        check_out("rstmid.pre", 12'h020, 32'h77, 1'b1);
        idle_inputs();
        rst = 1'b1;
        lsu_vld = 1'b1; lsu_idx = 4'd6; lsu_data = 32'h99;
        check_rdy("rstmid.rst", 1'b0, 1'b0);
        check_out("rstmid.post", 12'h000, 32'h0, 1'b0);
        rst = 1'b0;
        idle_inputs();

        // Illegal divider index: handshake completes, no write, sticky error.
        div_vld = 1'b1; div_idx = 4'd14; div_data = 32'hEEEE;
        check_rdy("illegal", 1'b0 == 1'b0, 1'b1);
        check_out("illegal", 12'h000, 32'h0, 1'b1);
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("illegal.sticky", 32'(idx_err), 32'h1);

        // Divider starves behind continuous LSU traffic.
        lsu_vld = 1'b1; lsu_idx = 4'd1; lsu_data = 32'h101;
        div_vld = 1'b1; div_idx = 4'd2; div_data = 32'hD1;
        for (int k = 0; k < 4; k++) begin
            string tag;
            tag = $sformatf("starve%0d", k);
            check_rdy(tag, 1'b1, 1'b0);
            check_out(tag, 12'h002, 32'h101, 1'b1);
        end
        check_rdy("starve.win", 1'b0, 1'b1);
        check_out("starve.win", 12'h004, 32'hD1, 1'b1);
        check_rdy("starve.after", 1'b1, 1'b0);
        check_out("starve.after", 12'h002, 32'h101, 1'b1);
        idle_inputs();

        rst = 1'b1;
        @(posedge clk);
        #1;
        check("final_reset.err", 32'(idx_err), 32'h0);
        check("final_reset.we",  32'(we), 32'h0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
